// File: rtl/dmem_access_ctrl_pkg.sv
// Shared RV32I load/store encodings and the data-memory access FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } dmem_ctrl_state_t;

endpackage

// File: rtl/dmem_access_ctrl_align.sv
// Lane steering for the data-memory port: byte enables, store data shift,
// alignment check for the incoming request, and load extraction/extension
// for the response of the access in flight.
module load_store_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  output logic [3:0]  mbe,
  output logic [31:0] wdata_shifted,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_ext
);

  logic [31:0] rdata_shifted;

  // Request side: enables, store lanes and alignment of the incoming packet.
  always_comb begin
    mbe           = 4'b1111;
    misaligned    = 1'b0;
    wdata_shifted = wdata << {addr_lo, 3'b000};
    if (is_store) begin
      case (funct3)
        sb:      mbe = 4'b0001 << addr_lo;
        sh:      begin mbe = 4'b0011 << addr_lo; misaligned = addr_lo[0]; end
        sw:      misaligned = |addr_lo;
        default: mbe = 4'b1111;
      endcase
    end else begin
      case (funct3)
        lh, lhu: misaligned = addr_lo[0];
        lw:      misaligned = |addr_lo;
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Response side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rdata_shifted = rdata >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      lb:      load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      lbu:     load_ext = {24'b0, rdata_shifted[7:0]};
      lh:      load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      lhu:     load_ext = {16'b0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-cache sequencer: turns one load/store into a held cache
// request, stalls the pipeline until the response, flags misaligned or
// conflicting packets and cache timeouts.
module dmem_access_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  dmem_ctrl_state_t state_q, state_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [3:0]       mbe_q, mbe_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  al_mbe;
  logic [31:0] al_wdata;
  logic        al_misaligned;
  logic [31:0] al_load;

  logic op, illegal, issue, wd_hit, timeout;

  load_store_align u_align (
    .funct3        (funct3),
    .addr_lo       (addr[1:0]),
    .is_store      (req_write),
    .wdata         (wdata),
    .mbe           (al_mbe),
    .wdata_shifted (al_wdata),
    .misaligned    (al_misaligned),
    .ld_funct3     (funct3_q),
    .ld_addr_lo    (off_q),
    .rdata         (dmem_rdata),
    .load_ext      (al_load)
  );

  // Request qualification and watchdog status for the current cycle.
  // The watchdog compare is independent of dmem_resp so the held request
  // never depends combinationally on the cache's answer; a resp arriving
  // in the expiry cycle still wins because timeout is gated by it.
  always_comb begin
    op      = req_valid & (req_read | req_write);
    illegal = (req_read & req_write) | al_misaligned;
    issue   = (state_q == IDLE) & op & ~illegal;
    wd_hit  = (TIMEOUT != 0) && (cnt_q == CNT_MAX);
    timeout = (state_q == ACCESS) & wd_hit & ~dmem_resp;
  end

  // Pipeline/cache handshake outputs derived from the registered state.
  always_comb begin
    stall        = 1'b0;
    err          = 1'b0;
    done         = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = addr_q;
    dmem_wdata   = wdata_q;
    dmem_mbe     = mbe_q;
    load_data    = load_data_q;
    case (state_q)
      IDLE: begin
        stall = issue;
        err   = op & illegal;
      end
      ACCESS: begin
        stall      = ~timeout;
        err        = timeout;
        dmem_read  = read_q & ~wd_hit;
        dmem_write = write_q & ~wd_hit;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic: latch the request on issue, wait for resp or expiry.
  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    write_d     = write_q;
    addr_d      = addr_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    mbe_d       = mbe_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = ACCESS;
          read_d   = req_read;
          write_d  = req_write;
          addr_d   = {addr[31:2], 2'b00};
          off_d    = addr[1:0];
          funct3_d = funct3;
          mbe_d    = al_mbe;
          wdata_d  = al_wdata;
          cnt_d    = '0;
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          state_d = DONE;
          if (read_q) load_data_d = al_load;
        end else if (wd_hit) begin
          state_d = IDLE;
        end
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      mbe_q       <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      mbe_q       <= mbe_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a byte-level memory model predicts
// each retirement; a cache responder with programmable latency serves the DUT.
module tb_dmem_access_ctrl;

  localparam int TO = 4;
  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_ERR   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_read, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] load_data;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .err(err), .load_data(load_data),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic [31:0] ld;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          retire_cnt = 0;
  logic [7:0]  mmem[64];
  logic [31:0] rmem[16];
  logic [31:0] model_ld = '0;
  int          resp_lat = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    rmem[i] = w;
    for (int k = 0; k < 4; k++) mmem[4*i+k] = w[8*k +: 8];
  endtask

  // Cache responder: answers resp_lat cycles after the request first appears.
  logic        busy = 1'b0;
  int          acc = 0;
  logic [31:0] r_addr, r_wd;
  logic [3:0]  r_mbe;
  logic        r_wr;
  initial begin dmem_resp = 1'b0; dmem_rdata = '0; end
  always @(negedge clk) begin
    dmem_resp = 1'b0;
    if (rst) busy = 1'b0;
    else begin
      if (!busy && (dmem_read || dmem_write)) begin
        busy = 1'b1; acc = 0;
        r_addr = dmem_address; r_wd = dmem_wdata; r_mbe = dmem_mbe; r_wr = dmem_write;
      end
      if (busy) begin
        acc++;
        if (resp_lat != 0 && acc == resp_lat) begin
          dmem_resp = 1'b1;
          busy = 1'b0;
          if (r_wr) begin
            for (int b = 0; b < 4; b++)
              if (r_mbe[b]) rmem[r_addr[5:2]][8*b +: 8] = r_wd[8*b +: 8];
            dmem_rdata = $urandom;
          end else begin
            dmem_rdata = rmem[r_addr[5:2]];
          end
        end else if (err) begin
          busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT retires (done or err).
  int          stall_cnt = 0;
  logic [31:0] o_addr, o_wd;
  logic [3:0]  o_mbe;
  logic [1:0]  o_dir;
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      stall_cnt = 0;
      o_dir = 2'b00;
    end else begin
      if (stall) stall_cnt++;
      if (dmem_read || dmem_write) begin
        o_dir = {dmem_read, dmem_write}; o_addr = dmem_address;
        o_mbe = dmem_mbe; o_wd = dmem_wdata;
      end
      if (done || err) begin
        retire_cnt++;
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_retire: done=%b err=%b with nothing outstanding", done, err);
        end else begin
          e = sb_q.pop_front();
          check("retire_kind", {30'b0, done, err}, (e.kind == K_ERR) ? 32'd1 : 32'd2);
          check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          check("req_dropped", {30'b0, dmem_read, dmem_write}, 32'd0);
          check("load_data", load_data, e.ld);
          if (e.kind != K_ERR) begin
            check("direction", {30'b0, o_dir}, (e.kind == K_LOAD) ? 32'd2 : 32'd1);
            check("address", o_addr, e.addr);
            check("mbe", {28'b0, o_mbe}, {28'b0, e.mbe});
            if (e.kind == K_STORE) check("store_wdata", o_wd, e.wdata);
          end
        end
        stall_cnt = 0;
        o_dir = 2'b00;
      end
    end
  end

  // Reference model + driver for one MEM packet.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int lat);
    exp_t e;
    int off, size, base, start;
    logic mis;
    logic [63:0] v;
    off  = int'(a[1:0]);
    base = int'(a[5:0]);
    size = 0;
    if (wr && !rd) size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    else if (f3 == 3'b000 || f3 == 3'b100) size = 1;
    else if (f3 == 3'b001 || f3 == 3'b101) size = 2;
    else if (f3 == 3'b010) size = 4;
    mis = (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
    e.addr = a & 32'hFFFF_FFFC;
    e.mbe = 4'b1111; e.wdata = '0; e.ld = model_ld;
    if ((rd && wr) || mis) begin
      e.kind = K_ERR; e.stalls = 0;
    end else if (lat == 0) begin
      e.kind = K_ERR; e.stalls = 1 + TO;
    end else if (rd) begin
      v = '0;
      if (size == 0) begin
        for (int k = off; k < 4; k++) v |= 64'(mmem[base - off + k]) << (8 * (k - off));
      end else begin
        for (int k = 0; k < size; k++) v |= 64'(mmem[base + k]) << (8 * k);
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
      end
      model_ld = v[31:0];
      e.kind = K_LOAD; e.ld = model_ld; e.stalls = 1 + lat;
    end else begin
      e.mbe = '0;
      for (int k = 0; k < size; k++) begin
        mmem[base + k] = wd[8*k +: 8];
        e.mbe[off + k] = 1'b1;
      end
      e.wdata = wd << (8 * off);
      e.kind = K_STORE; e.stalls = 1 + lat;
    end
    sb_q.push_back(e);
    resp_lat = lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
    start = retire_cnt;
    for (int i = 0; i < 40 && retire_cnt == start; i++) begin
      @(negedge clk); #3;
    end
    if (retire_cnt == start) begin
      total++; bad++;
      $display("FAIL retire_wait: no done/err within 40 cycles for addr %h", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
  endtask

  logic [2:0]  ld_f3s[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
  logic [31:0] rnd;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_dir", {30'b0, dmem_read, dmem_write}, 32'd0);
    check("rst_address", dmem_address, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_mbe", {28'b0, dmem_mbe}, 32'd0);

    set_word(0, 32'hDEAD_BEEF);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, '0, 3);
    set_word(0, 32'h80FF_0000);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0203, '0, 2);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0203, '0, 1);
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 2);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, '0, 1);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, '0, 0);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, '0, 1);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0104, '0, TO + 1);

    // Reset in the second ACCESS cycle abandons the request.
    resp_lat = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; model_ld = '0;
    @(negedge clk); #2;
    check("abort_read", {31'b0, dmem_read}, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_load_data", load_data, 32'd0);
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678, 2);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, '0, 1);

    for (int n = 0; n < 200; n++) begin
      int sel, l;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      rnd = $urandom;
      a = {rnd[31:6], 6'($urandom_range(0, 63))};
      l = $urandom_range(0, 15);
      l = (l == 0) ? 0 : (l % 5) + 1;
      if (sel == 0)
        run_op(1'b1, 1'b1, 3'b010, a, $urandom, l);
      else if (sel <= 5)
        run_op(1'b1, 1'b0, ld_f3s[$urandom_range(0, 7)], a, $urandom, l);
      else
        run_op(1'b0, 1'b1, 3'($urandom_range(0, 2)), a, $urandom, l);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-cache accesses for the MEM stage of the pipelined RV32I core.
- Turns one load or store in the MEM packet into a held read/write request to the data cache, then waits for dmem_resp.
- Generates byte enables, lane-shifted store data and sign/zero-extended load data.
- Stalls the pipeline until the access completes. Detects misaligned accesses and cache timeouts.

Parameters:
- TIMEOUT, 256, cycles allowed in ACCESS before an error abort; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM packet is valid
- req_read  in  1  packet is a load
- req_write  in  1  packet is a store
- funct3  in  3  RV32I load/store width and signedness
- addr  in  32  effective address (alu_out)
- wdata  in  32  store data (rs2_out)
- stall  out  1  hold IF through MEM this cycle
- done  out  1  one-cycle pulse when the access retires
- err  out  1  one-cycle pulse: misaligned, read+write together, or timeout
- load_data  out  32  extended load result, registered
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_mbe  out  4  byte enables
- dmem_resp  in  1  cache completion
- dmem_rdata  in  32  cache read data

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: on a clk edge with rst=1, state=IDLE and the watchdog counter clears. All outputs read 0 after that edge: stall, done, err, load_data, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe.
- Reset mid-access abandons the request with no done. The cache is reset by the same rst.
- Access condition: op = req_valid & (req_read | req_write).
- Illegal access: req_read & req_write together, or a misaligned access. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, legal op: stall=1 (combinational). At the next edge, register address/mbe/wdata/direction and go to ACCESS.
- IDLE, illegal op: err=1 and stall=0 in the same cycle. No cache request, no done. Stay in IDLE.
- IDLE, no op: stall=0.
- ACCESS: dmem_read or dmem_write=1 with address/mbe/wdata held stable. stall=1.
  - On dmem_resp=1: capture the extended load_data (loads only) and go to DONE.
  - Watchdog reaches TIMEOUT first: err pulse, drop the request, go to IDLE with stall=0 for that cycle.
  - If dmem_resp and the timeout occur on the same cycle, resp wins.
- DONE: done=1, stall=0, request deasserted, go to IDLE. The pipeline advances this cycle, so the same packet is never reissued.
- Minimum latency: 2 stall cycles (IDLE issue cycle plus one ACCESS cycle) before DONE.
- Byte enables:
  - sb: mbe = 4'b0001 << addr[1:0]
  - sh: mbe = 4'b0011 << addr[1:0]
  - sw: mbe = 4'b1111
  - loads: mbe = 4'b1111
- Store data: dmem_wdata = wdata << (8*addr[1:0]).
- Load data: shift dmem_rdata right by 8*addr[1:0], then extend.
  - lb: sign-extend bit 7. lbu: zero-extend byte.
  - lh: sign-extend bit 15. lhu: zero-extend halfword.
  - lw: full word.
  - Unknown funct3 on a load returns the full word.
- load_data holds its value until the next load completes. Stores leave load_data unchanged.
- Watchdog counter: width $clog2(TIMEOUT+1). Clears on entry to ACCESS and saturates; it does not wrap.

Decomposition:
- Package (rv32i_types): load_funct3_t and store_funct3_t already exist there; reuse them.
- Package addition: dmem_ctrl_state_t enum {IDLE, ACCESS, DONE}.
- Sub-module: load_store_align, purely combinational. Computes mbe, shifted wdata, misaligned flag and extended load data from funct3/addr/data.

Test Plan:
- lw at 0x100, resp 3 cycles after issue, rdata 0xDEADBEEF -> dmem_read held 3 cycles, address 0x100, mbe 1111, stall high 4 cycles, done pulse, load_data=0xDEADBEEF.
- lb at 0x203, rdata 0x80FF_0000 -> address 0x200, load_data=0xFFFFFF80. lbu same access -> 0x00000080.
- sh at 0x302, wdata 0x0000_ABCD -> dmem_write=1, address 0x300, mbe 1100, dmem_wdata 0xABCD0000, done after resp, load_data unchanged.
- lw at 0x101 -> err=1 same cycle, stall=0, no dmem_read, no done.
- TIMEOUT=4, no resp -> dmem_read high 4 cycles, then err pulse, IDLE; next lw completes normally.
- rst asserted in the 2nd ACCESS cycle -> after that edge dmem_read=0, stall=0, no done; following sw at 0x40 completes normally.
